sys_reset_sequencer: RTL

//  Parametrised reset generator/sequencer for the SoC top level. It replaces the single fixed

---
 rtl/sys_reset_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sys_reset_sequencer.sv
// Ordered multi-channel reset sequencer: holds every channel after a trigger, then releases
// channels in index order, pacing each release on the previous channel's ack or a timeout.
module sys_reset_sequencer #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned ACK_TIMEOUT    = 64,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                ext_reset,
  input  logic                sw_reset_req,
  input  logic [CHANNELS-1:0] chan_ack,
  output logic [CHANNELS-1:0] rst_n,
  output logic                seq_busy,
  output logic [1:0]          reset_cause,
  output logic [CHANNELS-1:0] timeout_err
);

  localparam int unsigned MAXC = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam int unsigned IW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_EXT = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;

  // The release itself happens on the HOLD->WAIT / WAIT->WAIT transition edge,
  // so no separate release state needs a cycle of its own.
  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d, idx_nxt;
  logic [CHANNELS-1:0]    rstn_q, rstn_d;
  logic                   busy_q, busy_d;
  logic [1:0]             cause_q, cause_d;
  logic [CHANNELS-1:0]    terr_q, terr_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_sync, trigger, ack_ok, tmo;

  assign ext_sync = sync_q[SYNC_STAGES-1];
  assign trigger  = ext_sync | sw_reset_req;
  assign idx_nxt  = idx_q + IW'(1);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstn_q  <= '0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_POR;
      terr_q  <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
      terr_q  <= terr_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ext_reset};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rstn_d  = rstn_q;
    cause_d = cause_q;
    terr_d  = terr_q;
    ack_ok  = 1'b0;
    tmo     = 1'b0;

    if (trigger) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rstn_d  = '0;
      terr_d  = '0;
      cause_d = ext_sync ? CAUSE_EXT : CAUSE_SW;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            rstn_d[0] = 1'b1;
            idx_d     = '0;
            cnt_d     = '0;
            state_d   = ST_WAIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_WAIT: begin
          ack_ok = (cnt_q >= CW'(STAGGER_CYCLES - 1)) && chan_ack[idx_q];
          tmo    = (cnt_q == CW'(ACK_TIMEOUT - 1));
          if (ack_ok || tmo) begin
            if (!ack_ok) terr_d[idx_q] = 1'b1;
            if (idx_q < IW'(CHANNELS - 1)) begin
              rstn_d[idx_nxt] = 1'b1;
              idx_d           = idx_nxt;
              cnt_d           = '0;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RUN: ;
        default: state_d = ST_HOLD;
      endcase
    end

    busy_d = ~&rstn_d;
  end

  assign rst_n       = rstn_q;
  assign seq_busy    = busy_q;
  assign reset_cause = cause_q;
  assign timeout_err = terr_q;

endmodule
